// File: rtl/dcache_pkg.sv
// Shared cache geometry and FSM encodings for the L1 cache controllers.
// Latency: n/a (constants only).
// Backpressure: n/a.
// Holds the default address/word/line geometry, the ignored byte-in-word bit
// count, and the miss-handling FSM state encodings used by the d/i controllers.
package dcache_pkg;

  localparam int DC_ADDR_WIDTH = 20;
  localparam int DC_DATA_WIDTH = 32;
  localparam int DC_NLINES     = 4;
  localparam int DC_LINE_WIDTH = 128;

  // Byte-in-word address bits; always ignored by the caches.
  localparam int BYTE_OFF_W = 2;

  // Default address split: offset [3:2], index [5:4], tag [ADDR_WIDTH-1:6].
  localparam int DC_OFF_LSB = BYTE_OFF_W;
  localparam int DC_IDX_LSB = 4;
  localparam int DC_TAG_LSB = 6;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WB   = 2'd1;
  localparam logic [1:0] ST_FILL = 2'd2;

endpackage

// File: rtl/dcache_array.sv
// Per-line valid/dirty/tag/data storage for the direct-mapped data cache.
// Latency: combinational read; writes take effect at the next clk edge.
// Backpressure: none; the controller guarantees at most one write per cycle.
// Ports: rd_idx -> rd_valid/rd_dirty/rd_tag/rd_line; one write port that
// either stores one word (wr_word, sets dirty), installs a full line
// (install, valid=1 dirty=0, new tag) or clears dirty (clr_dirty).
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NLINES     = DC_NLINES,
  parameter int LINE_WIDTH = DC_LINE_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int TAG_W      = 14,
  parameter int IDX_W      = $clog2(NLINES),
  parameter int OFF_W      = $clog2(LINE_WIDTH / DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic                  rd_dirty,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [LINE_WIDTH-1:0] rd_line,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic                  wr_word,
  input  logic [OFF_W-1:0]      wr_off,
  input  logic [DATA_WIDTH-1:0] wr_word_data,
  input  logic                  install,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [LINE_WIDTH-1:0] wr_line,
  input  logic                  clr_dirty
);

  logic [NLINES-1:0]     valid;
  logic [NLINES-1:0]     dirty;
  logic [TAG_W-1:0]      tags  [NLINES];
  logic [LINE_WIDTH-1:0] lines [NLINES];

  assign rd_valid = valid[rd_idx];
  assign rd_dirty = dirty[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_line  = lines[rd_idx];

  // Only the status bits need reset; tag/data are meaningless while invalid.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (install) begin
      valid[wr_idx] <= 1'b1;
      dirty[wr_idx] <= 1'b0;
    end else if (wr_word) begin
      dirty[wr_idx] <= 1'b1;
    end else if (clr_dirty) begin
      dirty[wr_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (install) begin
      tags[wr_idx]  <= wr_tag;
      lines[wr_idx] <= wr_line;
    end else if (wr_word) begin
      lines[wr_idx][wr_off*DATA_WIDTH +: DATA_WIDTH] <= wr_word_data;
    end
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back data cache controller behind the store buffer.
// Latency: zero-cycle load hit; miss costs (WB cycles)+(FILL cycles)+1.
// Backpressure: stall on load miss / WB / FILL; sb_wr_ready low unless a drain hits with no load.
// Ports: rd_* load lookup (rd_hit also feeds the store buffer), sb_wr_* drain
// handshake, stall to the pipeline, mem_* single line-wide memory request
// held until the one-cycle mem_ready pulse.
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH = DC_ADDR_WIDTH,
  parameter int DATA_WIDTH = DC_DATA_WIDTH,
  parameter int NLINES     = DC_NLINES,
  parameter int LINE_WIDTH = DC_LINE_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_hit,
  input  logic                  sb_wr_valid,
  input  logic [ADDR_WIDTH-1:0] sb_wr_addr,
  input  logic [DATA_WIDTH-1:0] sb_wr_data,
  output logic                  sb_wr_ready,
  output logic                  stall,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [LINE_WIDTH-1:0] mem_rdata
);

  localparam int OFF_W   = $clog2(LINE_WIDTH / DATA_WIDTH);
  localparam int IDX_W   = $clog2(NLINES);
  localparam int OFF_LSB = BYTE_OFF_W;
  localparam int IDX_LSB = OFF_LSB + OFF_W;
  localparam int TAG_LSB = IDX_LSB + IDX_W;
  localparam int TAG_W   = ADDR_WIDTH - TAG_LSB;

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] act_addr;
  logic [OFF_W-1:0]      act_off;
  logic [IDX_W-1:0]      act_idx;
  logic [TAG_W-1:0]      act_tag;
  logic                  line_valid;
  logic                  line_dirty;
  logic [TAG_W-1:0]      line_tag;
  logic [LINE_WIDTH-1:0] line_data;
  logic                  idle;
  logic                  line_hit;
  logic                  miss;
  logic [TAG_W-1:0]      miss_tag;
  logic [IDX_W-1:0]      miss_idx;
  logic                  clr_dirty;
  logic                  install;
  logic                  unused_byte_bits;

  // Loads win arbitration; a colliding drain simply retries next cycle.
  assign act_addr = rd_req ? rd_addr : sb_wr_addr;
  assign act_off  = act_addr[OFF_LSB +: OFF_W];
  assign act_idx  = act_addr[IDX_LSB +: IDX_W];
  assign act_tag  = act_addr[TAG_LSB +: TAG_W];
  assign unused_byte_bits = ^act_addr[OFF_LSB-1:0];

  assign idle     = (state == ST_IDLE) && !reset;
  assign line_hit = line_valid && (line_tag == act_tag);
  assign miss     = idle && (rd_req || sb_wr_valid) && !line_hit;

  assign rd_hit      = idle && rd_req && line_hit;
  assign rd_data     = rd_hit ? line_data[act_off*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign sb_wr_ready = idle && sb_wr_valid && !rd_req && line_hit;
  // A drain-only miss does not stall the pipeline; only loads need the hold.
  assign stall       = !reset && ((state != ST_IDLE) || (rd_req && !line_hit));

  assign clr_dirty = !reset && (state == ST_WB) && mem_ready;
  assign install   = !reset && (state == ST_FILL) && mem_ready;

  dcache_array #(
    .NLINES     (NLINES),
    .LINE_WIDTH (LINE_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .TAG_W      (TAG_W),
    .IDX_W      (IDX_W),
    .OFF_W      (OFF_W)
  ) u_array (
    .clk          (clk),
    .reset        (reset),
    .rd_idx       (act_idx),
    .rd_valid     (line_valid),
    .rd_dirty     (line_dirty),
    .rd_tag       (line_tag),
    .rd_line      (line_data),
    .wr_idx       (sb_wr_ready ? act_idx : miss_idx),
    .wr_word      (sb_wr_ready),
    .wr_off       (act_off),
    .wr_word_data (sb_wr_data),
    .install      (install),
    .wr_tag       (miss_tag),
    .wr_line      (mem_rdata),
    .clr_dirty    (clr_dirty)
  );

  // mem_* are registered so they stay stable for the whole wait on mem_ready;
  // synchronous reset drops the transfer and any later mem_ready is ignored
  // because the FSM is back in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      miss_tag  <= '0;
      miss_idx  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (miss) begin
            miss_tag <= act_tag;
            miss_idx <= act_idx;
            mem_req  <= 1'b1;
            if (line_valid && line_dirty) begin
              state     <= ST_WB;
              mem_we    <= 1'b1;
              mem_addr  <= {line_tag, act_idx, {IDX_LSB{1'b0}}};
              mem_wdata <= line_data;
            end else begin
              state    <= ST_FILL;
              mem_we   <= 1'b0;
              mem_addr <= {act_tag, act_idx, {IDX_LSB{1'b0}}};
            end
          end
        end
        ST_WB: begin
          if (mem_ready) begin
            state    <= ST_FILL;
            mem_we   <= 1'b0;
            mem_addr <= {miss_tag, miss_idx, {IDX_LSB{1'b0}}};
          end
        end
        ST_FILL: begin
          if (mem_ready) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Self-checking bench for dcache_ctrl: per-cycle vector table, two
// hand-written multi-cycle sequences (slow memory, reset mid-fill) and a
// randomized phase checked against a flat word-memory reference model.
module tb_dcache_ctrl;

  localparam int AW = 20;
  localparam int DW = 32;
  localparam int LW = 128;

  logic          clk = 1'b0;
  logic          reset;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          rd_hit;
  logic          sb_wr_valid;
  logic [AW-1:0] sb_wr_addr;
  logic [DW-1:0] sb_wr_data;
  logic          sb_wr_ready;
  logic          stall;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ready;
  logic [LW-1:0] mem_rdata;

  always #5 clk = ~clk;

  dcache_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .rd_req      (rd_req),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .rd_hit      (rd_hit),
    .sb_wr_valid (sb_wr_valid),
    .sb_wr_addr  (sb_wr_addr),
    .sb_wr_data  (sb_wr_data),
    .sb_wr_ready (sb_wr_ready),
    .stall       (stall),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_ready   (mem_ready),
    .mem_rdata   (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- reference model: flat memory ----------------
  logic [LW-1:0] main_mem [int];   // backing store, keyed by line address
  logic [DW-1:0] arch     [int];   // architectural word values, keyed by word address

  function automatic logic [DW-1:0] init_word(input int a);
    logic [31:0] x;
    x = a;
    return 32'hC0DE0000 ^ (x * 32'h00010193);
  endfunction

  function automatic logic [LW-1:0] mem_line(input int la);
    logic [LW-1:0] l;
    if (main_mem.exists(la)) return main_mem[la];
    for (int i = 0; i < 4; i++) l[i*32 +: 32] = init_word(la + 4*i);
    return l;
  endfunction

  function automatic int word_key(input logic [AW-1:0] a);
    return int'({a[AW-1:2], 2'b00});
  endfunction

  function automatic logic [DW-1:0] arch_word(input int wa);
    return arch.exists(wa) ? arch[wa] : init_word(wa);
  endfunction

  // ---------------- memory responder + cycle step ----------------
  bit resp_auto = 1'b0;
  bit pending   = 1'b0;
  int cnt       = 0;

  task automatic tick();
    @(posedge clk);
    #1;
    if (resp_auto) begin
      if (mem_ready) begin
        mem_ready = 1'b0;
        pending   = 1'b0;
      end else if (mem_req) begin
        if (!pending) begin
          pending = 1'b1;
          cnt     = $urandom_range(0, 3);
        end
        if (cnt == 0) begin
          check("mem_addr_align", mem_addr[3:0], 4'h0);
          if (mem_we) main_mem[int'(mem_addr)] = mem_wdata;
          else        mem_rdata = mem_line(int'(mem_addr));
          mem_ready = 1'b1;
        end else begin
          cnt--;
        end
      end
    end
  endtask

  task automatic do_op(input bit rp_in, input logic [AW-1:0] ra, input bit wp_in,
                       input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit rp;
    bit wp;
    int guard;
    rp = rp_in;
    wp = wp_in;
    guard = 0;
    while ((rp || wp) && guard < 80) begin
      tick();
      rd_req      = rp;
      rd_addr     = ra;
      sb_wr_valid = wp;
      sb_wr_addr  = wa;
      sb_wr_data  = wd;
      #1;
      if (rd_req) check("rnd_stall_ready", {stall, sb_wr_ready}, {!rd_hit, 1'b0});
      if (rp && rd_hit) begin
        check($sformatf("rnd_load_%05h", ra), rd_data, arch_word(word_key(ra)));
        rp = 1'b0;
      end
      if (wp && sb_wr_ready) begin
        arch[word_key(wa)] = wd;
        wp = 1'b0;
      end
      guard++;
    end
    check("rnd_op_done", {rp, wp}, 2'b00);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic          rd;
    logic [AW-1:0] ra;
    logic          sv;
    logic [AW-1:0] sa;
    logic [DW-1:0] sd;
    logic          mr;
    logic [LW-1:0] rdat;
    logic          eh;
    logic [DW-1:0] ed;
    logic          esb;
    logic          est;
    logic          emq;
    logic          ewe;
    logic [AW-1:0] ema;
    logic [LW-1:0] ewd;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic [AW-1:0] ra, input logic sv,
                              input logic [AW-1:0] sa, input logic [DW-1:0] sd, input logic mr,
                              input logic [LW-1:0] rdat, input logic eh, input logic [DW-1:0] ed,
                              input logic esb, input logic est, input logic emq, input logic ewe,
                              input logic [AW-1:0] ema, input logic [LW-1:0] ewd);
    vec_t v;
    v.rd = rd; v.ra = ra; v.sv = sv; v.sa = sa; v.sd = sd; v.mr = mr; v.rdat = rdat;
    v.eh = eh; v.ed = ed; v.esb = esb; v.est = est; v.emq = emq; v.ewe = ewe;
    v.ema = ema; v.ewd = ewd;
    return v;
  endfunction

  localparam logic [LW-1:0] L1   = 128'h00000044_00000033_000000BB_00000011;
  localparam logic [LW-1:0] VICT = 128'h00000044_00001234_000000BB_00005555;
  localparam logic [LW-1:0] L2   = 128'h000000D3_000000D2_000000D1_000000D0;
  localparam logic [LW-1:0] LC   = 128'h000000C3_000000C2_000000C1_000000C0;

  vec_t vecs[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] got;
    logic [255:0] exp;

    //        rd  ra     sv sa     sd       mr rdata  eh ed        sb st mq we ma      wdata
    vecs.push_back(mk(0, 0,      0, 0,     0,       0, 0,    0, 0,        0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    0, 0,        0, 1, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    0, 0,        0, 1, 1, 0, 'h40,   0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       1, L1,   0, 0,        0, 1, 1, 0, 'h40,   0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    1, 'h11,     0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h44,   0, 0,     0,       0, 0,    1, 'hBB,     0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 'h48,  'h1234,  0, 0,    0, 0,        1, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h48,   0, 0,     0,       0, 0,    1, 'h1234,   0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h4C,   1, 'h40,  'h5555,  0, 0,    1, 'h44,     0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 'h40,  'h5555,  0, 0,    0, 0,        1, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    1, 'h5555,   0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       0, 0,    0, 0,        0, 1, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       0, 0,    0, 0,        0, 1, 1, 1, 'h40,   VICT));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       1, 0,    0, 0,        0, 1, 1, 1, 'h40,   VICT));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       0, 0,    0, 0,        0, 1, 1, 0, 'h440,  0));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       1, L2,   0, 0,        0, 1, 1, 0, 'h440,  0));
    vecs.push_back(mk(1, 'h440,  0, 0,     0,       0, 0,    1, 'hD0,     0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    0, 0,        0, 1, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    0, 0,        0, 1, 1, 0, 'h40,   0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       1, VICT, 0, 0,        0, 1, 1, 0, 'h40,   0));
    vecs.push_back(mk(1, 'h40,   0, 0,     0,       0, 0,    1, 'h5555,   0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 'h80,  'h77,    0, 0,    0, 0,        0, 0, 0, 0, 0,      0));
    vecs.push_back(mk(0, 0,      1, 'h80,  'h77,    0, 0,    0, 0,        0, 1, 1, 0, 'h80,   0));
    vecs.push_back(mk(0, 0,      1, 'h80,  'h77,    1, 0,    0, 0,        0, 1, 1, 0, 'h80,   0));
    vecs.push_back(mk(0, 0,      1, 'h80,  'h77,    0, 0,    0, 0,        1, 0, 0, 0, 0,      0));
    vecs.push_back(mk(1, 'h80,   0, 0,     0,       0, 0,    1, 'h77,     0, 0, 0, 0, 0,      0));

    // Reset with requests present: everything must read as zero.
    reset = 1'b1; rd_req = 1'b0; rd_addr = '0; sb_wr_valid = 1'b0; sb_wr_addr = '0;
    sb_wr_data = '0; mem_ready = 1'b0; mem_rdata = '0;
    repeat (2) tick();
    rd_req = 1'b1; rd_addr = 'h40; sb_wr_valid = 1'b1; sb_wr_addr = 'h40;
    #1;
    check("reset_outputs", {rd_hit, rd_data, sb_wr_ready, stall, mem_req, mem_we, mem_addr, mem_wdata}, '0);
    tick();
    reset = 1'b0; rd_req = 1'b0; sb_wr_valid = 1'b0;

    foreach (vecs[i]) begin
      tick();
      rd_req = vecs[i].rd; rd_addr = vecs[i].ra;
      sb_wr_valid = vecs[i].sv; sb_wr_addr = vecs[i].sa; sb_wr_data = vecs[i].sd;
      mem_ready = vecs[i].mr; mem_rdata = vecs[i].rdat;
      #1;
      got = {rd_hit, vecs[i].eh ? rd_data : 32'h0, sb_wr_ready, stall, mem_req,
             vecs[i].emq ? mem_we : 1'b0, vecs[i].emq ? mem_addr : 20'h0,
             (vecs[i].emq && vecs[i].ewe) ? mem_wdata : 128'h0};
      exp = {vecs[i].eh, vecs[i].ed, vecs[i].esb, vecs[i].est, vecs[i].emq,
             vecs[i].ewe, vecs[i].ema, vecs[i].ewd};
      check($sformatf("vec%0d", i), got, exp);
    end

    // Slow memory: dirty line 0x80 written back while mem_ready is withheld.
    tick();
    rd_req = 1'b1; rd_addr = 'hC0; sb_wr_valid = 1'b0; mem_ready = 1'b0;
    #1;
    check("dly_miss", {rd_hit, stall, mem_req}, 3'b010);
    for (int k = 0; k < 10; k++) begin
      tick();
      #1;
      check($sformatf("dly_hold%0d", k), {stall, mem_req, mem_we, mem_addr, mem_wdata},
            {1'b1, 1'b1, 1'b1, 20'h00080, 128'h77});
    end
    tick(); mem_ready = 1'b1; #1;
    tick(); mem_ready = 1'b0; #1;
    check("dly_fill", {stall, mem_req, mem_we, mem_addr}, {3'b110, 20'h000C0});
    tick(); mem_ready = 1'b1; mem_rdata = LC; #1;
    tick(); mem_ready = 1'b0; #1;
    check("dly_hit", {rd_hit, stall, rd_data}, {2'b10, 32'hC0});

    // Reset in the middle of a fill; the late mem_ready must not install.
    tick(); rd_addr = 'h100; #1;
    check("rst_miss", {rd_hit, stall, mem_req}, 3'b010);
    tick(); #1;
    check("rst_fill", {stall, mem_req, mem_we, mem_addr}, {3'b110, 20'h00100});
    tick(); reset = 1'b1; #1;
    tick(); reset = 1'b0; rd_req = 1'b0; #1;
    check("rst_idle", {stall, mem_req, mem_we, rd_hit, sb_wr_ready, mem_addr, mem_wdata}, '0);
    tick(); mem_ready = 1'b1; mem_rdata = {4{32'hDEADBEEF}}; #1;
    tick(); mem_ready = 1'b0; rd_req = 1'b1; rd_addr = 'h100; #1;
    check("rst_late_ready", {rd_hit, stall}, 2'b01);
    tick(); rd_req = 1'b0;
    check("rst_old_line", {rd_hit, sb_wr_ready}, 2'b00);

    // Randomized phase from a clean cache and memory.
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0; mem_ready = 1'b0; pending = 1'b0; resp_auto = 1'b1;
    main_mem.delete();
    arch.delete();
    for (int n = 0; n < 400; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      do_op(kind != 1, AW'($urandom_range(0, 255)), kind != 0,
            AW'($urandom_range(0, 255)), $urandom());
    end
    // Sweep every word so dirty data lost on eviction would show up.
    for (int a = 0; a < 256; a += 4) do_op(1'b1, AW'(a), 1'b0, '0, '0);

    tick();
    rd_req = 1'b0; sb_wr_valid = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
- Direct-mapped, write-back data cache controller, directly downstream of the store buffer.
- Consumes store-buffer drain writes and services pipeline load lookups.
- Drives the per-address hit flag the store buffer uses for load and store decisions.
- Owns the single line-wide request/response interface to main memory; stalls the pipeline on misses.

Parameters:
- ADDR_WIDTH, 20, byte address width
- DATA_WIDTH, 32, word width
- NLINES, 4, number of cache lines (power of 2)
- LINE_WIDTH, 128, line width in bits (4 words)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- rd_req  in  1  load lookup request from pipeline
- rd_addr  in  ADDR_WIDTH  load byte address (word aligned)
- rd_data  out  DATA_WIDTH  load word, valid when rd_hit=1
- rd_hit  out  1  load address present in cache (to pipeline and to store buffer cache_hit)
- sb_wr_valid  in  1  store buffer drains one entry
- sb_wr_addr  in  ADDR_WIDTH  drain address
- sb_wr_data  in  DATA_WIDTH  drain word
- sb_wr_ready  out  1  drain accepted this cycle
- stall  out  1  pipeline must hold
- mem_req  out  1  memory request, held until mem_ready
- mem_we  out  1  1 = line writeback, 0 = line fill
- mem_addr  out  ADDR_WIDTH  line-aligned address (low 4 bits zero)
- mem_wdata  out  LINE_WIDTH  victim line for writeback
- mem_ready  in  1  one-cycle pulse: request complete
- mem_rdata  in  LINE_WIDTH  fill data, valid with mem_ready

Behaviour:
- Address split (defaults): word offset [3:2], index [5:4], tag [ADDR_WIDTH-1:6]. Bits [1:0] are ignored.
- Per-line state: valid, dirty, tag, data.
- Reset:
  - Clears all valid and dirty bits; FSM returns to IDLE.
  - mem_req, mem_we, sb_wr_ready, stall, rd_hit are 0; rd_data is 0; mem_addr and mem_wdata are 0.
  - Reset mid-miss abandons the transfer. A mem_ready arriving after reset is ignored.
- Lookup is combinational on the state register and current inputs. rd_hit and rd_data are valid in the same cycle (zero-latency hit).
- FSM states: IDLE, WB (writeback), FILL.
- Request selection in IDLE: rd_req has priority over sb_wr_valid. The selected request's address is the active address.
- IDLE, load hit: rd_hit=1, rd_data = selected word, stall=0.
- IDLE, drain hit with no rd_req:
  - sb_wr_ready=1; the word is written at the clock edge; dirty is set.
  - Both requests in the same cycle: sb_wr_ready=0; the drain retries next cycle.
- IDLE, miss on the active request:
  - stall=1 and the miss address is latched.
  - Victim valid & dirty: go to WB with mem_req=1, mem_we=1, mem_addr={victim tag, index, 4'b0}, mem_wdata=victim line.
  - Otherwise: go to FILL with mem_req=1, mem_we=0, mem_addr={miss tag, index, 4'b0}.
- WB: hold all mem outputs stable while waiting. On mem_ready, clear dirty and go to FILL.
- FILL: hold mem outputs. On mem_ready, install mem_rdata with valid=1, dirty=0 and the new tag, then go to IDLE.
- Replay: the stalled request is held by the pipeline and re-evaluated in IDLE on the next cycle, where it hits. Miss-to-hit latency is (WB cycles) + (FILL cycles) + 1.
- stall:
  - 1 in WB and FILL.
  - 1 in IDLE on a load miss; a drain-only miss asserts stall=0 but holds sb_wr_ready=0.
  - mem_req deasserts in the cycle after mem_ready, when the FSM changes state.
- No state changes on rd_req or sb_wr_valid while in WB or FILL. rd_hit=0 and sb_wr_ready=0 in those states.
- Index aliasing: a miss evicts the resident line unconditionally; there is no victim buffer.

Decomposition:
- Shared header: ADDR_WIDTH, DATA_WIDTH, line geometry, offset/index/tag bit-range macros, FSM state encodings (also used by the icache controller).
- One sub-module: dcache_array (valid/dirty/tag/data storage, combinational read, single write port with word-enable or full-line install).

Test Plan:
- After reset, rd_req addr 0x00040 -> rd_hit=0, stall=1, mem_req=1, mem_we=0, mem_addr=0x00040. mem_ready with rdata word1=0xBB -> next cycle rd_hit=1; rd_addr 0x00044 returns 0xBB.
- Line 0x00040 resident; sb_wr_valid addr 0x00048 data 0x1234 -> sb_wr_ready=1 same cycle; subsequent load 0x00048 returns 0x1234 and the line is dirty.
- Dirty line 0x00040; load 0x00440 (same index, tag differs):
  - WB issued: mem_we=1, mem_addr=0x00040, mem_wdata word2=0x1234.
  - mem_ready -> FILL, mem_addr=0x00440.
  - mem_ready -> hit next cycle.
- rd_req hit and sb_wr_valid in the same cycle -> rd_hit=1, sb_wr_ready=0; next cycle without rd_req -> sb_wr_ready=1.
- mem_ready delayed 10 cycles -> mem_req, mem_addr, mem_wdata stable for all 10 cycles; stall=1 throughout.
- reset asserted during FILL -> next cycle mem_req=0, stall=0, all lines invalid; a late mem_ready pulse causes no install (load of same address misses again).
